load: RTL and testbench
=======================

LOAD -- requirements
Module: load

Interface
REQ-001 Port clk, input, 1 bit; the only clock, all state updates on its rising edge.
REQ-002 Port rst, input, 1 bit; reset is synchronous and active-high.
REQ-003 Port r1, input, 5 bits; source register index (rs1).
REQ-004 Port r2, input, 5 bits; destination register index (rd).
REQ-005 Port offset, input, 12 bits; signed two's-complement immediate.
REQ-006 Port a, output, 64 bits; current contents of register x[r1].
REQ-007 Port rd, output, 64 bits; effective address.
REQ-008 Port readdata, output, 64 bits; memory doubleword at the effective address.
REQ-009 Positional port order SHALL be r1, r2, offset, clk, a, rd, readdata, rst.

Function
REQ-010 The module SHALL contain a register file of 32 x 64-bit registers, x0..x31.
REQ-011 x0 SHALL always read as 0; writes to x0 SHALL be discarded.
REQ-012 The module SHALL contain a data memory of 256 x 64-bit doublewords, mem[0..255], read-only to this block.
REQ-013 a SHALL equal x[r1] combinationally (0 when r1 = 0).
REQ-014 rd SHALL equal a + sign-extend-64(offset), computed combinationally modulo 2^64.
- Offset range is -2048..+2047.
- Carry out is discarded.
REQ-015 Memory SHALL be doubleword-indexed by rd[7:0]; rd[63:8] SHALL be ignored, so indices wrap modulo 256.
REQ-016 readdata SHALL equal mem[rd[7:0]] combinationally, with zero-cycle read latency.
REQ-017 On each rising clk with rst = 0, x[r2] SHALL be loaded with readdata, unless r2 = 0.
REQ-018 Outputs SHALL reflect the new register contents right after the edge (one-cycle writeback latency).
REQ-019 When r1 = r2, the value used during the cycle SHALL be the old x[r1]; the update SHALL be visible only after the edge.
REQ-020 There SHALL be no handshake and no stall; one load is committed per clock.
REQ-021 Inputs SHALL be sampled only at the rising edge for the write; between edges, outputs track input changes combinationally.

Reset
REQ-022 On a rising clk with rst = 1, x[i] SHALL become i for i = 1..31, and x0 SHALL be 0.
REQ-023 On a rising clk with rst = 1, mem[k] SHALL become 64'h1000 + k for k = 0..255.
REQ-024 Reset SHALL take priority over writeback: no register write occurs on a reset edge, including when reset asserts mid-sequence.
REQ-025 After reset, outputs SHALL be the combinational function of the reset state.
- Example: r1 = 0, offset = 0 gives a = 0, rd = 0, readdata = 64'h1000.

Verification
REQ-026 Basic load.
- Stimulus: reset, then r1 = 2, r2 = 6, offset = 6.
- Before the edge: a = 2, rd = 8, readdata = 64'h1008.
- After the edge: x6 = 64'h1008.
REQ-027 Dependent load.
- Stimulus: continuing from REQ-026, r1 = 6, r2 = 7, offset = 10.
- Response: a = 64'h1008, rd = 64'h1012, readdata = 64'h1012.
- After the edge: x7 = 64'h1012.
REQ-028 Negative offset and wrap.
- Stimulus: after reset, r1 = 0, r2 = 4, offset = 12'hFFF.
- Response: rd = 64'hFFFF_FFFF_FFFF_FFFF, readdata = 64'h10FF.
- After the edge: x4 = 64'h10FF.
REQ-029 x0 protection.
- Stimulus: r1 = 14, r2 = 0, offset = 15.
- Response: a = 14, rd = 29, readdata = 64'h101D.
- After the edge: x0 still reads 0.
REQ-030 Reset priority.
- Stimulus: drive a load with r2 = 6 while rst = 1 on the edge.
- Response: x6 = 6 after the edge, and a = 6 when r1 = 6.
REQ-031 Self-overwrite.
- Stimulus: r1 = r2 = 3, offset = 1.
- Cycle 1: a = 3, rd = 4; after the edge x3 = 64'h1004.
- Next cycle: a = 64'h1004, rd = 64'h1005, readdata = 64'h1005.

Source files
------------

// File: rtl/load.sv
// ---------------------------------------------------------------------------
// load : 32x64 register file feeding a 256x64 read-only data memory,
//        one "ld x[r2], offset(x[r1])" committed per clock.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module load (
  input  logic [4:0]  r1,
  input  logic [4:0]  r2,
  input  logic [11:0] offset,
  input  logic        clk,
  output logic [63:0] a,
  output logic [63:0] rd,
  output logic [63:0] readdata,
  input  logic        rst
);

  localparam int unsigned NREGS     = 32;
  localparam int unsigned MEM_DEPTH = 256;
  localparam logic [63:0] MEM_BASE  = 64'h1000;

  // x0 is hard-wired to zero, so only x1..x31 need storage.
  logic [63:0] regs_q [1:NREGS-1];
  logic [63:0] regs_d [1:NREGS-1];
  logic [63:0] mem_q  [0:MEM_DEPTH-1];
  logic [63:0] rf_view [0:NREGS-1];
  logic [63:0] offset_sext;

  always_comb begin
    rf_view[0] = '0;
    for (int i = 1; i < NREGS; i++) begin
      rf_view[i] = regs_q[i];
    end
  end

  always_comb begin
    offset_sext = {{52{offset[11]}}, offset};
    a           = rf_view[r1];
    rd          = a + offset_sext;
    readdata    = mem_q[rd[7:0]];
  end

  always_comb begin
    for (int i = 1; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (r2 != 5'd0) begin
      regs_d[r2] = readdata;
    end
  end

  // Reset wins over writeback; a load presented on a reset edge is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < NREGS; i++) begin
        regs_q[i] <= 64'(i);
      end
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < MEM_DEPTH; k++) begin
        mem_q[k] <= MEM_BASE + 64'(k);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_load.sv
// Self-checking bench for load: directed vector table, a few hand sequences,
// then randomized loads against an array-based reference model.
`default_nettype none

module tb_load;

  logic [4:0]  r1, r2;
  logic [11:0] offset;
  logic        clk, rst;
  logic [63:0] a, rd, readdata;

  int checks = 0;
  int errors = 0;

  load dut (
    .r1(r1), .r2(r2), .offset(offset), .clk(clk),
    .a(a), .rd(rd), .readdata(readdata), .rst(rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: architectural state as plain arrays.
  logic [63:0] mx [32];
  logic [63:0] mm [256];

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mx[i] = 64'(i);
    for (int k = 0; k < 256; k++) mm[k] = 64'd4096 + 64'(k);
  endtask

  function automatic logic [63:0] m_a(input logic [4:0] s);
    return (s == 5'd0) ? 64'd0 : mx[s];
  endfunction

  function automatic logic [63:0] m_ea(input logic [4:0] s, input logic [11:0] off);
    int so;
    so = (int'(off) >= 2048) ? int'(off) - 4096 : int'(off);
    return m_a(s) + 64'(longint'(so));
  endfunction

  function automatic logic [63:0] m_data(input logic [4:0] s, input logic [11:0] off);
    return mm[int'(m_ea(s, off) % 64'd256)];
  endfunction

  task automatic model_edge(input logic rs, input logic [4:0] s, input logic [4:0] d,
                            input logic [11:0] off);
    logic [63:0] v;
    if (rs) model_reset();
    else if (d != 5'd0) begin
      v = m_data(s, off);
      mx[d] = v;
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rs;
    logic [4:0]  s1;
    logic [4:0]  s2;
    logic [11:0] off;
    logic [63:0] ea;
    logic [63:0] erd;
    logic [63:0] edata;
  } vec_t;

  vec_t vt [14];

  // Apply one vector just after a rising edge, check at the falling edge,
  // then let the next rising edge commit it.
  task automatic run_vec(input vec_t v, input string tag);
    rst = v.rs; r1 = v.s1; r2 = v.s2; offset = v.off;
    @(negedge clk);
    check({tag, ".a"}, a, v.ea);
    check({tag, ".rd"}, rd, v.erd);
    check({tag, ".readdata"}, readdata, v.edata);
    @(posedge clk);
    model_edge(v.rs, v.s1, v.s2, v.off);
    #1;
  endtask

  initial begin
    vt[0]  = '{1'b0, 5'd0,  5'd0, 12'd0,   64'd0,      64'd0,      64'h1000};
    vt[1]  = '{1'b0, 5'd2,  5'd6, 12'd6,   64'd2,      64'd8,      64'h1008};
    vt[2]  = '{1'b0, 5'd6,  5'd7, 12'd10,  64'h1008,   64'h1012,   64'h1012};
    vt[3]  = '{1'b0, 5'd7,  5'd0, 12'd0,   64'h1012,   64'h1012,   64'h1012};
    vt[4]  = '{1'b0, 5'd14, 5'd0, 12'd15,  64'd14,     64'd29,     64'h101D};
    vt[5]  = '{1'b0, 5'd0,  5'd0, 12'd0,   64'd0,      64'd0,      64'h1000};
    vt[6]  = '{1'b1, 5'd0,  5'd6, 12'd0,   64'd0,      64'd0,      64'h1000};
    vt[7]  = '{1'b0, 5'd6,  5'd0, 12'd0,   64'd6,      64'd6,      64'h1006};
    vt[8]  = '{1'b0, 5'd0,  5'd4, 12'hFFF, 64'd0,      '1,         64'h10FF};
    vt[9]  = '{1'b0, 5'd4,  5'd0, 12'd0,   64'h10FF,   64'h10FF,   64'h10FF};
    vt[10] = '{1'b0, 5'd3,  5'd3, 12'd1,   64'd3,      64'd4,      64'h1004};
    vt[11] = '{1'b0, 5'd3,  5'd3, 12'd1,   64'h1004,   64'h1005,   64'h1005};
    vt[12] = '{1'b0, 5'd3,  5'd0, 12'd0,   64'h1005,   64'h1005,   64'h1005};
    vt[13] = '{1'b0, 5'd6,  5'd0, 12'h800, 64'd6,      64'hFFFF_FFFF_FFFF_F806, 64'h1006};

    rst = 1'b1; r1 = '0; r2 = '0; offset = '0;
    @(posedge clk);
    model_reset();
    #1;

    for (int i = 0; i < 14; i++) run_vec(vt[i], $sformatf("vec%0d", i));

    // Reset held over several edges with a pending load, then combinational
    // tracking of input changes between edges.
    rst = 1'b1; r1 = 5'd9; r2 = 5'd9; offset = 12'd3;
    repeat (3) @(posedge clk);
    model_reset();
    #1;
    rst = 1'b0; r1 = 5'd9; r2 = 5'd0; offset = 12'd0;
    #1;
    check("hold_rst.a", a, 64'd9);
    r1 = 5'd5; offset = 12'hFFF;
    #1;
    check("comb.a", a, 64'd5);
    check("comb.rd", rd, 64'd4);
    check("comb.readdata", readdata, 64'h1004);
    r1 = 5'd31; offset = 12'h7FF;
    #1;
    check("comb_max.rd", rd, 64'd31 + 64'd2047);
    check("comb_max.readdata", readdata, 64'h1000 + 64'((31 + 2047) % 256));
    @(posedge clk);
    #1;

    // Randomized loads against the reference model.
    for (int n = 0; n < 400; n++) begin
      vec_t v;
      v.rs  = ($urandom_range(0, 31) == 0);
      v.s1  = 5'($urandom_range(0, 31));
      v.s2  = ($urandom_range(0, 3) == 0) ? v.s1 : 5'($urandom_range(0, 31));
      v.off = 12'($urandom);
      v.ea    = m_a(v.s1);
      v.erd   = m_ea(v.s1, v.off);
      v.edata = m_data(v.s1, v.off);
      run_vec(v, $sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
